// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the fetch FSM state encoding.
package cpu_pkg;
   localparam int N_DEF = 16;
   localparam int W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_stall_counter.sv
// Saturating 16-bit count of fetch stall cycles; present only in FETCH_STALL_CNT_EN builds.
module fetch_stall_counter (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        inc_i,
   output logic [15:0] cnt_o
);
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge Clock) begin
      if (!Reset) cnt_q <= 16'd0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage with branch redirect/squash.
// Optional macro FETCH_STALL_CNT_EN adds the Stall_cnt output.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic [N-1:0] PC_value,
   output logic [N-1:0] PC_next,
   output logic         PC_write_data,
   output logic [N-1:0] Mem_addr,
   output logic         Mem_req,
   input  logic         Mem_ack,
   input  logic [W-1:0] Mem_rdata,
   output logic [W-1:0] Instr,
   output logic [N-1:0] Instr_PC,
   output logic         Instr_valid,
   input  logic         Instr_ready,
`ifdef FETCH_STALL_CNT_EN
   output logic [15:0]  Stall_cnt,
`endif
   input  logic         Redirect,
   input  logic [N-1:0] Redirect_target
);
   fetch_state_t state_q;
   logic         mem_req_q;
   logic         valid_q;
   logic         squash_q;
   logic [W-1:0] instr_q;
   logic [N-1:0] instr_pc_q;

   assign Mem_addr    = PC_value;
   assign Mem_req     = mem_req_q;
   assign Instr       = instr_q;
   assign Instr_PC    = instr_pc_q;
   assign Instr_valid = valid_q;

   // Redirect wins over the increment; a squashed ack never advances the PC.
   always_comb begin
      PC_write_data = 1'b0;
      PC_next       = PC_value + N'(1);
      if (!Reset) begin
         PC_next = '0;
      end else if (Redirect) begin
         PC_write_data = 1'b1;
         PC_next       = Redirect_target;
      end else if ((state_q == REQ) && Mem_ack && !squash_q) begin
         PC_write_data = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q    <= IDLE;
         mem_req_q  <= 1'b0;
         valid_q    <= 1'b0;
         squash_q   <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q   <= REQ;
               mem_req_q <= 1'b1;
            end
            REQ: begin
               if (Mem_ack) begin
                  squash_q <= 1'b0;
                  if (!(Redirect || squash_q)) begin
                     instr_q    <= Mem_rdata;
                     instr_pc_q <= PC_value;
                     valid_q    <= 1'b1;
                     mem_req_q  <= 1'b0;
                     state_q    <= HOLD;
                  end
               end else if (Redirect) begin
                  squash_q <= 1'b1;
               end
            end
            HOLD: begin
               if (Redirect || Instr_ready) begin
                  valid_q   <= 1'b0;
                  mem_req_q <= 1'b1;
                  state_q   <= REQ;
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
               valid_q   <= 1'b0;
               squash_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_STALL_CNT_EN
   logic stall_inc;
   assign stall_inc = ((state_q == REQ) && !Mem_ack) || ((state_q == HOLD) && !Instr_ready);

   fetch_stall_counter u_stall_cnt (
      .Clock (Clock),
      .Reset (Reset),
      .inc_i (stall_inc),
      .cnt_o (Stall_cnt)
   );
`else
   // Stall instrumentation is not built.
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC register model and a simple instruction memory.
module tb_instruction_fetch;
   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] PC_value;
   logic [15:0] PC_next;
   logic        PC_write_data;
   logic [15:0] Mem_addr;
   logic        Mem_req;
   logic        Mem_ack;
   logic [15:0] Mem_rdata;
   logic [15:0] Instr;
   logic [15:0] Instr_PC;
   logic        Instr_valid;
   logic        Instr_ready;
   logic        Redirect;
   logic [15:0] Redirect_target;
`ifdef FETCH_STALL_CNT_EN
   logic [15:0] Stall_cnt;
`endif

   logic        ack_auto, ack_man, pc_load;
   logic [15:0] pc_load_val;
   int          checks = 0;
   int          failures = 0;

   always #5 Clock = ~Clock;

   instruction_fetch dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .PC_value        (PC_value),
      .PC_next         (PC_next),
      .PC_write_data   (PC_write_data),
      .Mem_addr        (Mem_addr),
      .Mem_req         (Mem_req),
      .Mem_ack         (Mem_ack),
      .Mem_rdata       (Mem_rdata),
      .Instr           (Instr),
      .Instr_PC        (Instr_PC),
      .Instr_valid     (Instr_valid),
      .Instr_ready     (Instr_ready),
`ifdef FETCH_STALL_CNT_EN
      .Stall_cnt       (Stall_cnt),
`endif
      .Redirect        (Redirect),
      .Redirect_target (Redirect_target)
   );

   // Program counter register fed back by the fetch stage.
   always @(posedge Clock) begin
      if (pc_load)            PC_value <= pc_load_val;
      else if (PC_write_data) PC_value <= PC_next;
   end

   always_comb begin
      Mem_ack   = ack_auto ? Mem_req : ack_man;
      Mem_rdata = 16'hA000 ^ Mem_addr;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      Reset = 1'b0; Instr_ready = 1'b1; Redirect = 1'b0; Redirect_target = 16'h0;
      ack_auto = 1'b0; ack_man = 1'b0; pc_load = 1'b1; pc_load_val = 16'h1234;
      PC_value = 16'h0;
      tick(); tick();
      chk("rst_mem_req", Mem_req, 0);
      chk("rst_valid", Instr_valid, 0);
      chk("rst_instr", Instr, 0);
      chk("rst_instr_pc", Instr_PC, 0);
      chk("rst_pc_write", PC_write_data, 0);
      chk("rst_pc_next", PC_next, 0);
      chk("rst_mem_addr", Mem_addr, 16'h1234);
      pc_load_val = 16'h0000;
      tick();
      pc_load = 1'b0;

      // Release reset: one IDLE cycle, then zero-wait fetches of PC 0..4.
      Reset = 1'b1; ack_auto = 1'b1;
      #1 chk("idle_mem_req", Mem_req, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("req%0d_mem_req", i), Mem_req, 1);
         chk($sformatf("req%0d_addr", i), Mem_addr, i);
         chk($sformatf("req%0d_pc_write", i), PC_write_data, 1);
         chk($sformatf("req%0d_pc_next", i), PC_next, i + 1);
         tick();
         chk($sformatf("hold%0d_valid", i), Instr_valid, 1);
         chk($sformatf("hold%0d_instr_pc", i), Instr_PC, i);
         chk($sformatf("hold%0d_instr", i), Instr, 16'hA000 ^ i);
         chk($sformatf("hold%0d_pc_write", i), PC_write_data, 0);
         chk($sformatf("hold%0d_mem_req", i), Mem_req, 0);
         tick();
      end

      // Delayed ack at PC=5: three wait cycles, then ack.
      ack_auto = 1'b0; ack_man = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("wait%0d_mem_req", k), Mem_req, 1);
         chk($sformatf("wait%0d_addr", k), Mem_addr, 5);
         chk($sformatf("wait%0d_pc_write", k), PC_write_data, 0);
         tick();
      end
      ack_man = 1'b1;
      #1;
      chk("ack5_mem_req", Mem_req, 1);
      chk("ack5_addr", Mem_addr, 5);
      chk("ack5_pc_write", PC_write_data, 1);
      chk("ack5_pc_next", PC_next, 6);
      tick();
      ack_man = 1'b0;
      chk("hold5_instr_pc", Instr_PC, 5);
      chk("hold5_instr", Instr, 16'hA005);

      // Decode back-pressure for four cycles.
      Instr_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("stall%0d_valid", k), Instr_valid, 1);
         chk($sformatf("stall%0d_instr", k), Instr, 16'hA005);
         chk($sformatf("stall%0d_instr_pc", k), Instr_PC, 5);
         chk($sformatf("stall%0d_mem_req", k), Mem_req, 0);
         chk($sformatf("stall%0d_pc_write", k), PC_write_data, 0);
         tick();
      end
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cnt_after_hold", Stall_cnt, 7);
`endif
      Instr_ready = 1'b1;
      tick();

      // Redirect to 0x0040 while the PC=6 request is outstanding.
      chk("pre_redir_addr", Mem_addr, 6);
      Redirect = 1'b1; Redirect_target = 16'h0040;
      #1;
      chk("redir_pc_write", PC_write_data, 1);
      chk("redir_pc_next", PC_next, 16'h0040);
      tick();
      Redirect = 1'b0;
      chk("squash_mem_req", Mem_req, 1);
      chk("squash_addr", Mem_addr, 16'h0040);
      ack_man = 1'b1;
      #1;
      chk("squash_ack_pc_write", PC_write_data, 0);
      tick();
      ack_man = 1'b0;
      chk("squash_valid", Instr_valid, 0);
      chk("squash_next_req", Mem_req, 1);
      chk("squash_next_addr", Mem_addr, 16'h0040);
      ack_man = 1'b1;
      #1;
      chk("ack40_pc_write", PC_write_data, 1);
      chk("ack40_pc_next", PC_next, 16'h0041);
      tick();
      ack_man = 1'b0;
      chk("hold40_valid", Instr_valid, 1);
      chk("hold40_instr_pc", Instr_PC, 16'h0040);
      chk("hold40_instr", Instr, 16'hA040);

      // Redirect in HOLD to 0xFFFF drops the held word; then fetch wraps.
      Instr_ready = 1'b0; Redirect = 1'b1; Redirect_target = 16'hFFFF;
      #1;
      chk("hredir_pc_write", PC_write_data, 1);
      chk("hredir_pc_next", PC_next, 16'hFFFF);
      tick();
      Redirect = 1'b0;
      chk("hredir_valid", Instr_valid, 0);
      chk("hredir_mem_req", Mem_req, 1);
      chk("hredir_addr", Mem_addr, 16'hFFFF);
      ack_man = 1'b1;
      #1;
      chk("wrap_pc_write", PC_write_data, 1);
      chk("wrap_pc_next", PC_next, 16'h0000);
      tick();
      ack_man = 1'b0;
      chk("wrap_instr_pc", Instr_PC, 16'hFFFF);
      chk("wrap_valid", Instr_valid, 1);
      chk("wrap_pc_value", PC_value, 16'h0000);
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cnt_after_redir", Stall_cnt, 9);
`endif

      // Reset asserted in the middle of a REQ.
      Instr_ready = 1'b1;
      tick();
      chk("prerst_mem_req", Mem_req, 1);
      Reset = 1'b0;
      #1;
      chk("rstlow_pc_write", PC_write_data, 0);
      chk("rstlow_pc_next", PC_next, 0);
      tick();
      chk("midrst_mem_req", Mem_req, 0);
      chk("midrst_valid", Instr_valid, 0);
      chk("midrst_instr", Instr, 0);
`ifdef FETCH_STALL_CNT_EN
      chk("midrst_stall_cnt", Stall_cnt, 0);
`endif
      Reset = 1'b1;
      #1 chk("rel_idle_mem_req", Mem_req, 0);
      tick();
      chk("rel_first_mem_req", Mem_req, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of the program counter: reads the current PC, issues one instruction-memory read per instruction over a req/ack handshake, and holds the returned word for decode behind a valid/ready handshake. It also produces the next PC and the PC write enable that feed back into the program counter, and applies branch redirects. One instruction is in flight at a time, with no prefetch.

## Interface
- N, 16: PC / address width.
- W, 16: instruction word width.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- PC_value  in  N  current PC from the program counter.
- PC_next  out  N  value loaded into the program counter.
- PC_write_data  out  1  program counter load enable; the PC loads PC_next at the same edge.
- Mem_addr  out  N  instruction memory address; combinational copy of PC_value.
- Mem_req  out  1  read request.
- Mem_ack  in  1  read done; Mem_rdata is valid this cycle.
- Mem_rdata  in  W  instruction word.
- Instr  out  W  fetched instruction, registered.
- Instr_PC  out  N  address of Instr, registered.
- Instr_valid  out  1  Instr is valid for decode.
- Instr_ready  in  1  decode accepts.
- Redirect  in  1  branch/jump taken, single-cycle pulse.
- Redirect_target  in  N  new PC.

## Operation
- States:
  - IDLE: one cycle after reset, then goes to REQ.
  - REQ: Mem_req=1, waits for Mem_ack.
  - HOLD: Instr_valid=1, waits for Instr_ready.
- REQ with Mem_ack=1:
  - Instr←Mem_rdata, Instr_PC←PC_value.
  - PC_write_data=1 and PC_next=PC_value+1, both combinational in the ack cycle.
  - Next state is HOLD.
- HOLD with Instr_ready=1: handshake completes and the next state is REQ, which uses the already-updated PC.
- Mem_req stays high in REQ until Mem_ack; there is no abort.
- PC arithmetic is modulo 2^N, so 0xFFFF+1 wraps to 0x0000.
- Redirect always forces PC_write_data=1 and PC_next=Redirect_target. It takes priority over the increment in the same cycle. Per state:
  - IDLE: the redirect is loaded and the FSM proceeds normally.
  - HOLD: the held instruction is dropped, Instr_valid=0 from the next cycle, and the next state is REQ. If Instr_ready=1 in the same cycle, the handshake counts as accepted.
  - REQ with Mem_ack: the data is discarded and the next state is REQ.
  - REQ without Mem_ack: the squash flag is set and Mem_req stays high. When the ack arrives, the data is discarded, there is no PC write unless another Redirect is present, the flag clears and the state stays REQ.
- Reset (Reset=0 at an edge) from any state:
  - State→IDLE; Instr, Instr_PC, Instr_valid, Mem_req and squash flag→0.
  - PC_write_data=0 and PC_next=0 while Reset is low.
  - An outstanding memory request is abandoned; memory must tolerate Mem_req dropping.

## Timing
- Reset values: Mem_req=0, Instr_valid=0, Instr=0, Instr_PC=0, PC_write_data=0, PC_next=0. Mem_addr follows PC_value.
- First Mem_req is 2 cycles after Reset deasserts: the IDLE cycle, then REQ.
- With zero-wait memory (Mem_ack in the first REQ cycle) and Instr_ready=1, throughput is one instruction per 2 cycles.
- Instr_valid rises in the cycle after the Mem_ack edge.
- Instr and Instr_PC are stable while Instr_valid=1 && Instr_ready=0.
- PC_write_data is high for exactly one cycle per accepted ack or redirect, and never otherwise.

## Configuration
- FETCH_STALL_CNT_EN defined:
  - Adds output Stall_cnt (16 bits), reset to 0.
  - Increments each cycle in REQ without Mem_ack, or in HOLD with Instr_ready=0.
  - Saturates at 0xFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - Default widths N and W.
  - Fetch state encoding fetch_state_t (IDLE=2'd0, REQ=2'd1, HOLD=2'd2).
- Stall counter is the one natural sub-module, fetch_stall_counter, instantiated only under FETCH_STALL_CNT_EN.
- The FSM and datapath stay in instruction_fetch.

## Test plan
- Reset, zero-wait memory, Instr_ready=1, PC starts at 0 -> Instr_PC sequence 0,1,2,3, one every 2 cycles; PC_write_data pulses once per fetch.
- Mem_ack delayed 3 cycles at PC=5 -> Mem_req high 4 cycles, Mem_addr=5 throughout; Instr_PC=5 with Mem_rdata captured; PC_next=6.
- HOLD with Instr_ready=0 for 4 cycles -> Instr stable, no new Mem_req; with FETCH_STALL_CNT_EN, Stall_cnt=4.
- Redirect to 0x0040 during REQ before a delayed ack -> ack data not presented, next Mem_addr=0x0040, no increment PC write on the squashed ack.
- PC_value=0xFFFF, ack -> PC_next=0x0000.
- Reset low mid-REQ -> Mem_req=0 and Instr_valid=0 next cycle; after release, first Mem_req 2 cycles later.
